// File: rtl/ttl_scan_mux.sv
// ttl_scan_mux: registered N-channel selector with direct and auto-scan modes.
// Optional y_par output enabled by defining TTL_SCAN_MUX_PARITY_EN.
module ttl_scan_mux #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      y_valid,
`ifdef TTL_SCAN_MUX_PARITY_EN
  output logic                      y_par,
`endif
  output logic                      scan_wrap
);

  typedef enum logic [1:0] {
    DISABLED,
    DIRECT,
    SCAN
  } state_t;

  localparam logic [SEL_W:0]   NCH   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [7:0]       DLAST = 8'(DWELL - 1);

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic [SEL_W-1:0] nxt, cur_n;
  logic [WIDTH-1:0] y_n;
  logic             valid_n, wrap_n;

  function automatic logic [WIDTH-1:0] pick(
    input logic [SEL_W-1:0]          s,
    input logic [CHANNELS*WIDTH-1:0] d
  );
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (s == SEL_W'(k))
        w = d[k*WIDTH +: WIDTH];
    return w;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    nxt     = cur_sel;
    cur_n   = cur_sel;
    y_n     = '0;
    valid_n = 1'b0;
    wrap_n  = 1'b0;
    unique case (1'b1)
      enable_n: begin
        state_n = DISABLED;
      end
      (!enable_n && !mode): begin
        state_n = DIRECT;
        cnt_n   = '0;
        nxt     = sel;
        cur_n   = sel;
        if ({1'b0, sel} < NCH) begin
          y_n     = pick(sel, data);
          valid_n = 1'b1;
        end
      end
      (!enable_n && mode && state != SCAN): begin
        state_n = SCAN;
        cnt_n   = '0;
        nxt     = ({1'b0, sel} < NCH) ? sel : '0;
        cur_n   = nxt;
        y_n     = pick(nxt, data);
        valid_n = 1'b1;
      end
      default: begin
        if (cnt == DLAST) begin
          cnt_n  = '0;
          nxt    = (cur_sel == LAST) ? '0 : cur_sel + SEL_W'(1);
          wrap_n = (cur_sel == LAST);
        end else begin
          cnt_n = cnt + 8'd1;
          nxt   = cur_sel;
        end
        cur_n   = nxt;
        y_n     = pick(nxt, data);
        valid_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= DISABLED;
      cnt       <= '0;
      y         <= '0;
      cur_sel   <= '0;
      y_valid   <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      y         <= y_n;
      cur_sel   <= cur_n;
      y_valid   <= valid_n;
      scan_wrap <= wrap_n;
    end
  end

`ifdef TTL_SCAN_MUX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) y_par <= 1'b0;
    else       y_par <= ^y_n;
  end
`endif

endmodule
